// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-channel TDM demultiplexer: slot-word input stream and
// rebuilt channel/status outputs.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             sof;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [1:0]       slot;
  logic             locked;
  logic             frame_valid;
  logic             sync_err;

  modport master (
    output din, din_valid, sof,
    input  A, B, C, D, slot, locked, frame_valid, sync_err
  );

  modport slave (
    input  din, din_valid, sof,
    output A, B, C, D, slot, locked, frame_valid, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Rebuilds four channels A..D from a TDM slot stream; a frame is committed to
// the outputs only when all four slots arrive in order.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  state_e           r_state;
  logic [1:0]       r_slot;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic             r_frame_valid;
  logic             r_sync_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StHunt;
      r_slot        <= 2'd0;
      r_sh0         <= '0;
      r_sh1         <= '0;
      r_sh2         <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_c           <= '0;
      r_d           <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (bus.din_valid) begin
        unique case (r_state)
          StHunt: begin
            if (bus.sof) begin
              r_sh0   <= bus.din;
              r_slot  <= 2'd1;
              r_state <= StLocked;
            end
          end
          StLocked: begin
            if (bus.sof) begin
              // sof anywhere but slot 0 abandons the partial frame and resyncs
              r_sync_err <= (r_slot != 2'd0);
              r_sh0      <= bus.din;
              r_slot     <= 2'd1;
            end else begin
              unique case (r_slot)
                2'd0: begin
                  r_sync_err <= 1'b1;
                  r_slot     <= 2'd0;
                  r_state    <= StHunt;
                end
                2'd1: begin
                  r_sh1  <= bus.din;
                  r_slot <= 2'd2;
                end
                2'd2: begin
                  r_sh2  <= bus.din;
                  r_slot <= 2'd3;
                end
                2'd3: begin
                  r_a           <= r_sh0;
                  r_b           <= r_sh1;
                  r_c           <= r_sh2;
                  r_d           <= bus.din;
                  r_frame_valid <= 1'b1;
                  r_slot        <= 2'd0;
                end
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.A           = r_a;
  assign bus.B           = r_b;
  assign bus.C           = r_c;
  assign bus.D           = r_d;
  assign bus.slot        = r_slot;
  assign bus.locked      = (r_state == StLocked);
  assign bus.frame_valid = r_frame_valid;
  assign bus.sync_err    = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: completed frames are pushed to a scoreboard
// when their D word is driven and popped when frame_valid is seen.
module tb_tdm_demux4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   fv_cnt;
  logic [15:0] exp_q[$];

  tdm_demux4_if #(.WIDTH(4)) bus ();

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] d, input logic s, input logic v);
    @(negedge clk);
    bus.din       = d;
    bus.sof       = s;
    bus.din_valid = v;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'h0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input int gap);
    drive(a, 1'b1, 1'b1);
    idle(gap);
    drive(b, 1'b0, 1'b1);
    idle(gap);
    drive(c, 1'b0, 1'b1);
    idle(gap);
    exp_q.push_back({a, b, c, d});
    drive(d, 1'b0, 1'b1);
  endtask

  function automatic logic [15:0] abcd();
    return {bus.A, bus.B, bus.C, bus.D};
  endfunction

  // Scoreboard side: every frame_valid pulse must match a pushed frame
  always @(negedge clk) begin
    if (rst_n && bus.frame_valid) begin
      fv_cnt++;
      check("frame_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("frame_data", abcd(), exp_q.pop_front());
      check("fv_err_excl", 16'(bus.sync_err), 16'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r0, r1, r2, r3;
    int fv0;
    n_tests = 0;
    n_fail  = 0;
    fv_cnt  = 0;
    bus.din = 4'h0;
    bus.sof = 1'b0;
    bus.din_valid = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check("reset_abcd", abcd(), 16'h0000);
    check("reset_slot", 16'(bus.slot), 16'd0);
    check("reset_locked", 16'(bus.locked), 16'd0);
    check("reset_fv", 16'(bus.frame_valid), 16'd0);
    check("reset_err", 16'(bus.sync_err), 16'd0);
    rst_n = 1'b1;

    // Back-to-back frame
    send_frame(4'h0, 4'hA, 4'hF, 4'h9, 0);
    idle(1);
    check("t1_abcd", abcd(), 16'h0AF9);
    check("t1_fv", 16'(bus.frame_valid), 16'd1);
    check("t1_slot", 16'(bus.slot), 16'd0);
    check("t1_locked", 16'(bus.locked), 16'd1);
    idle(1);
    check("t1_fv_pulse", 16'(bus.frame_valid), 16'd0);

    // Same frame with idle gaps
    fv0 = fv_cnt;
    send_frame(4'h0, 4'hA, 4'hF, 4'h9, 3);
    idle(1);
    check("t2_abcd", abcd(), 16'h0AF9);
    check("t2_fv", 16'(bus.frame_valid), 16'd1);
    idle(3);
    check("t2_fv_once", 16'(fv_cnt - fv0), 16'd1);

    // Hunt discards sof=0 words silently
    @(negedge clk) rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    drive(4'h5, 1'b0, 1'b1);
    drive(4'h6, 1'b0, 1'b1);
    idle(1);
    check("t3_hunt_locked", 16'(bus.locked), 16'd0);
    check("t3_hunt_err", 16'(bus.sync_err), 16'd0);
    check("t3_hunt_slot", 16'(bus.slot), 16'd0);
    send_frame(4'h1, 4'h2, 4'h3, 4'h4, 0);
    idle(1);
    check("t3_abcd", abcd(), 16'h1234);

    // Early sof resyncs without touching A..D
    drive(4'hF, 1'b1, 1'b1);
    drive(4'hE, 1'b0, 1'b1);
    drive(4'h1, 1'b1, 1'b1);
    idle(1);
    check("t4_err", 16'(bus.sync_err), 16'd1);
    check("t4_locked", 16'(bus.locked), 16'd1);
    check("t4_slot", 16'(bus.slot), 16'd1);
    check("t4_hold", abcd(), 16'h1234);
    drive(4'h2, 1'b0, 1'b1);
    drive(4'h3, 1'b0, 1'b1);
    exp_q.push_back(16'h1234);
    drive(4'h4, 1'b0, 1'b1);
    idle(1);
    check("t4_abcd", abcd(), 16'h1234);
    check("t4_err_clear", 16'(bus.sync_err), 16'd0);

    // Missing sof at slot 0 drops lock
    drive(4'h8, 1'b0, 1'b1);
    idle(1);
    check("t5_err", 16'(bus.sync_err), 16'd1);
    check("t5_locked", 16'(bus.locked), 16'd0);
    check("t5_slot", 16'(bus.slot), 16'd0);
    check("t5_hold", abcd(), 16'h1234);
    idle(1);
    check("t5_err_pulse", 16'(bus.sync_err), 16'd0);

    // Asynchronous reset mid-frame
    drive(4'h7, 1'b1, 1'b1);
    drive(4'h8, 1'b0, 1'b1);
    idle(1);
    check("t6_slot2", 16'(bus.slot), 16'd2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_abcd", abcd(), 16'h0000);
    check("t6_slot", 16'(bus.slot), 16'd0);
    check("t6_locked", 16'(bus.locked), 16'd0);
    @(negedge clk) rst_n = 1'b1;

    // Random frame after recovery
    r0 = 4'($urandom_range(0, 15));
    r1 = 4'($urandom_range(0, 15));
    r2 = 4'($urandom_range(0, 15));
    r3 = 4'($urandom_range(0, 15));
    send_frame(r0, r1, r2, r3, int'($urandom_range(0, 2)));
    idle(1);
    check("t7_abcd", abcd(), {r0, r1, r2, r3});
    idle(3);
    check("sb_drained", 16'(exp_q.size()), 16'd0);
    check("fv_total", 16'(fv_cnt), 16'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4-to-1 MUX: rebuilds four 4-bit channels A..D from one time-division-multiplexed word stream.
- Each frame is four slots in the order A, B, C, D. A start-of-frame flag marks slot A.
- A slot counter and a lock state machine track frame position; a completed frame updates the outputs atomically.
- Sits at the far end of a TDM link fed by the mux plus a rotating 2-bit select.

Parameters:
- WIDTH, 4, bit width of each channel word and of din.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  multiplexed data word.
- din_valid  input  1  din is a valid slot word this cycle.
- sof  input  1  start of frame; meaningful only when din_valid=1; marks slot A.
- A  output  WIDTH  channel A word of the last complete frame (slot 0).
- B  output  WIDTH  channel B word of the last complete frame (slot 1).
- C  output  WIDTH  channel C word of the last complete frame (slot 2).
- D  output  WIDTH  channel D word of the last complete frame (slot 3).
- slot  output  2  slot index expected for the next valid word.
- locked  output  1  high while in state LOCKED.
- frame_valid  output  1  one-cycle pulse: A..D were just updated.
- sync_err  output  1  one-cycle pulse: framing violation detected.

Behaviour:
- Reset is asynchronous on rst_n low: state=HUNT, slot=0, A=B=C=D=0, shadow registers=0, locked=0, frame_valid=0, sync_err=0.
- Reset mid-frame discards the partial frame; A..D return to 0.
- All other state changes happen on the rising edge of clk only. All outputs are registered.
- din_valid=0: no state, slot or data change. Gaps of any length between slots are legal. frame_valid and sync_err deassert.
- HUNT state:
  - Valid words with sof=0 are discarded silently; sync_err is not asserted.
  - On din_valid&sof: shadow0<=din, slot<=1, go to LOCKED.
- LOCKED state, valid word arrives:
  - slot=0, sof=1: shadow0<=din, slot<=1.
  - slot=0, sof=0: word discarded, sync_err pulse, go to HUNT, slot<=0.
  - slot=1 or 2, sof=0: shadow[slot]<=din, slot<=slot+1.
  - slot=3, sof=0: A<=shadow0, B<=shadow1, C<=shadow2, D<=din, all on the same edge. frame_valid pulses for exactly one cycle. slot wraps to 0.
  - slot=1..3, sof=1 (early sof): sync_err pulse, partial frame discarded with A..D unchanged, shadow0<=din, slot<=1, stay LOCKED (resync).
- Latency: A..D and frame_valid are visible in the cycle after the edge that samples the slot-3 word.
- A..D hold their values between frames; only a complete four-slot frame updates them.
- frame_valid and sync_err are never high in the same cycle.
- locked = (state==LOCKED).

Test Plan:
- Reset, then a frame sof+0000, 1010, 1111, 1001 on consecutive cycles -> after 4th edge A=0000 B=1010 C=1111 D=1001; frame_valid high for exactly 1 cycle; slot=0; locked=1.
- Same frame with 3 idle cycles (din_valid=0) between each slot -> identical A..D; frame_valid asserts only once, after the D word.
- In HUNT, send 0101 and 0110 with sof=0, then a valid frame sof+0001, 0010, 0011, 0100 -> first two words ignored; sync_err stays 0; A..D=0001/0010/0011/0100.
- Locked after one frame: send sof+1111, 1110, then sof+0001, 0010, 0011, 0100 -> sync_err pulse on the second sof; A..D unchanged until the resynced frame completes, then A..D=0001/0010/0011/0100.
- Locked at slot 0: send 1000 with sof=0 -> sync_err pulse; locked=0; A..D unchanged.
- Assert rst_n=0 asynchronously mid-frame (slot=2) -> A..D=0, slot=0, locked=0 immediately, without waiting for a clk edge.
